ysyx_220053_mem_arbiter: RTL and testbench
==========================================

Name: ysyx_220053_mem_arbiter

Overview:
- Shares the single data-memory port (the pmem read/write unit driven by MemOp/addr/wdata/wen) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, registers it and drives it to memory with a valid/ready handshake.
- Waits for the memory response and returns it to the requester that owns the transaction.
- LSU has fixed priority, bounded by an anti-starvation counter for the IFU.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, memory data width
STARVE_MAX, 4, max consecutive LSU grants while IFU is waiting; range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  one-cycle fetch response pulse
ifu_rdata  out  32  instruction word
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  load/store accepted this cycle
lsu_addr  in  ADDR_W  byte address
lsu_memop  in  3  MemOp (bit2 = zero-extend; [1:0]: 00 word, 01 byte, 10 half, 11 double)
lsu_wen  in  1  1 = store
lsu_wdata  in  DATA_W  store data, LSB-aligned
lsu_resp_valid  out  1  one-cycle load/store response pulse (stores also acknowledged)
lsu_rdata  out  DATA_W  load data, already extended by memory
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_memop  out  3  registered MemOp
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered store data
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE, owner = NONE, starve_cnt = 0.
  - All *_valid and *_ready outputs are 0.
  - mem_addr, mem_memop, mem_wen, mem_wdata, ifu_rdata and lsu_rdata are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational: ready = (state == IDLE) && grant to that requester.
  - LSU wins when both requesters are valid, unless starve_cnt == STARVE_MAX; then IFU wins.
  - On grant, the request fields are captured into the mem_* registers, owner is recorded, and the FSM goes to ISSUE.
- IFU capture values: mem_memop = 3'b100 (4-byte, zero-extended), mem_wen = 0, mem_wdata = 0.
- ISSUE:
  - mem_req_valid = 1 with the mem_* fields held stable.
  - Moves to WAIT on mem_req_ready.
  - mem_resp_valid in ISSUE is ignored; memory must respond no earlier than the cycle after it accepts.
- WAIT:
  - On mem_resp_valid, the response is registered into the owner's rdata, the FSM goes to RESP, and owner_resp_valid is set.
- RESP:
  - Exactly one cycle with owner_resp_valid = 1; the other requester's resp_valid stays 0.
  - Then returns to IDLE.
  - No new grant is made in RESP.
- Response data:
  - ifu_rdata = mem_rdata[31:0].
  - lsu_rdata = mem_rdata, including for store acknowledgements.
  - Neither changes except on the owner's response.
- Minimum latency, with zero-wait memory: accept at c0, issue and memory accept at c1, mem_resp_valid at c2, resp_valid at c3, next grant possible at c4.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each LSU grant while ifu_req_valid = 1.
  - Clears to 0 on any IFU grant.
  - Holds on LSU grants when the IFU is not waiting.
- Requesters hold their fields until ready. The arbiter does not depend on this after the accept cycle.
- Address alignment and byte-lane masking belong to memory; addresses are passed unchanged.
- rst asserted in any state returns the block to IDLE next cycle. The outstanding transaction is abandoned with no response pulse. A late mem_resp_valid seen in IDLE is ignored.

Decomposition:
- Shared package:
  - MemOp constants (MEMOP_W = 3'b000, MEMOP_B, MEMOP_H, MEMOP_D, MEMOP_WU = 3'b100, MEMOP_BU, MEMOP_HU).
  - FSM state encoding.
  - Owner encoding (NONE/IFU/LSU).
- Sub-module ysyx_220053_mem_arb_pick: combinational priority and starvation pick.
  - Inputs: ifu_valid, lsu_valid, starve_cnt.
  - Outputs: grant_ifu, grant_lsu.
  - The counter register stays in the top module.

Test Plan:
1. IFU only, addr 0x80000000, zero-wait memory, mem_rdata 0xFFFFFFFF00000013 → mem_memop = 3'b100, mem_wen = 0; ifu_resp_valid pulses 1 cycle at c3 with ifu_rdata = 0x00000013; lsu_resp_valid stays 0.
2. Both requesters valid in IDLE, starve_cnt = 0 → lsu_req_ready = 1, ifu_req_ready = 0; the IFU is granted in the next IDLE once LSU drops valid.
3. STARVE_MAX = 4, LSU and IFU valid continuously → grant sequence L, L, L, L, I, L; starve_cnt is 0 right after the IFU grant.
4. LSU store, memop 3'b001, addr 0x800020d1, wdata 0xAB, mem_req_ready held low 3 cycles → mem_addr, mem_memop and mem_wdata stay stable with mem_req_valid = 1 throughout; lsu_resp_valid pulses once.
5. rst asserted for 1 cycle in WAIT → next cycle all valids and readies are 0; mem_resp_valid 2 cycles later produces no resp pulse; a new IFU request is granted normally.
6. mem_resp_valid asserted in ISSUE together with mem_req_ready → no response pulse; the FSM waits in WAIT for the next mem_resp_valid.

Source files
------------

// File: rtl/ysyx_220053_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU data-memory arbiter: MemOp codes,
// FSM state encoding and transaction owner encoding.
package ysyx_220053_mem_arbiter_pkg;

   // MemOp: bit2 = zero-extend, [1:0] = size (00 word, 01 byte, 10 half, 11 double)
   localparam logic [2:0] MEMOP_W  = 3'b000;
   localparam logic [2:0] MEMOP_B  = 3'b001;
   localparam logic [2:0] MEMOP_H  = 3'b010;
   localparam logic [2:0] MEMOP_D  = 3'b011;
   localparam logic [2:0] MEMOP_WU = 3'b100;
   localparam logic [2:0] MEMOP_BU = 3'b101;
   localparam logic [2:0] MEMOP_HU = 3'b110;

   // Wide enough for the largest allowed STARVE_MAX (15)
   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IFU  = 2'd1,
      OWN_LSU  = 2'd2
   } arb_owner_e;

endpackage

// File: rtl/ysyx_220053_mem_arb_pick.sv
// Combinational requester pick: LSU has priority unless the IFU has been
// passed over STARVE_MAX times in a row, in which case the IFU wins.
module ysyx_220053_mem_arb_pick
   import ysyx_220053_mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                    ifu_valid,
   input  logic                    lsu_valid,
   input  logic [STARVE_CNT_W-1:0] starve_cnt,
   output logic                    grant_ifu,
   output logic                    grant_lsu
);

   logic ifu_starved;

   assign ifu_starved = ifu_valid && (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

   // At most one grant; the IFU takes the slot whenever the LSU does not
   always_comb begin
      grant_lsu = lsu_valid && !ifu_starved;
      grant_ifu = ifu_valid && !grant_lsu;
   end

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// Shares one data-memory port between the IFU and the LSU. One transaction
// is in flight at a time: grant in IDLE, present to memory in ISSUE, wait for
// the read data in WAIT, pulse the owner's response in RESP.
module ysyx_220053_mem_arbiter
   import ysyx_220053_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [31:0]       ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [2:0]        lsu_memop,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_memop,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e              state_q;
   arb_owner_e              owner_q;
   logic [STARVE_CNT_W-1:0] starve_q;
   logic                    mem_req_valid_q;
   logic [ADDR_W-1:0]       mem_addr_q;
   logic [2:0]              mem_memop_q;
   logic                    mem_wen_q;
   logic [DATA_W-1:0]       mem_wdata_q;
   logic                    ifu_resp_valid_q;
   logic                    lsu_resp_valid_q;
   logic [31:0]             ifu_rdata_q;
   logic [DATA_W-1:0]       lsu_rdata_q;
   logic                    pick_ifu;
   logic                    pick_lsu;
   logic                    idle;

   assign idle = (state_q == ST_IDLE);

   ysyx_220053_mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
      .starve_cnt (starve_q),
      .grant_ifu  (pick_ifu),
      .grant_lsu  (pick_lsu)
   );

   // Nothing is accepted while reset is held, even if the FSM is already idle
   assign ifu_req_ready  = idle && !rst && pick_ifu;
   assign lsu_req_ready  = idle && !rst && pick_lsu;

   assign mem_req_valid  = mem_req_valid_q;
   assign mem_addr       = mem_addr_q;
   assign mem_memop      = mem_memop_q;
   assign mem_wen        = mem_wen_q;
   assign mem_wdata      = mem_wdata_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign lsu_rdata      = lsu_rdata_q;

   // Arbitration FSM with registered memory request and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         owner_q          <= OWN_NONE;
         starve_q         <= '0;
         mem_req_valid_q  <= 1'b0;
         mem_addr_q       <= '0;
         mem_memop_q      <= '0;
         mem_wen_q        <= 1'b0;
         mem_wdata_q      <= '0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         ifu_rdata_q      <= '0;
         lsu_rdata_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_lsu) begin
                  mem_addr_q      <= lsu_addr;
                  mem_memop_q     <= lsu_memop;
                  mem_wen_q       <= lsu_wen;
                  mem_wdata_q     <= lsu_wdata;
                  owner_q         <= OWN_LSU;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= ST_ISSUE;
                  // Count only grants that made a waiting IFU lose
                  if (ifu_req_valid && (starve_q != STARVE_CNT_W'(STARVE_MAX))) begin
                     starve_q <= starve_q + STARVE_CNT_W'(1);
                  end
               end else if (pick_ifu) begin
                  mem_addr_q      <= ifu_addr;
                  mem_memop_q     <= MEMOP_WU;
                  mem_wen_q       <= 1'b0;
                  mem_wdata_q     <= '0;
                  owner_q         <= OWN_IFU;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= ST_ISSUE;
                  starve_q        <= '0;
               end
            end
            ST_ISSUE: begin
               // A response in this state is not ours yet and is dropped
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  state_q <= ST_RESP;
                  if (owner_q == OWN_IFU) begin
                     ifu_rdata_q      <= mem_rdata[31:0];
                     ifu_resp_valid_q <= 1'b1;
                  end else begin
                     lsu_rdata_q      <= mem_rdata;
                     lsu_resp_valid_q <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               ifu_resp_valid_q <= 1'b0;
               lsu_resp_valid_q <= 1'b0;
               owner_q          <= OWN_NONE;
               state_q          <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios followed by random
// traffic, checked by a scoreboard monitor against a transaction-level model.
module tb_ysyx_220053_mem_arbiter;

   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 64;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic [31:0]       ifu_rdata;
   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic [2:0]        lsu_memop;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_rdata;
   logic              mem_req_valid;
   logic              mem_req_ready  = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_memop;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_resp_valid = 1'b0;
   logic [DATA_W-1:0] mem_rdata      = '0;

   always #5 clk = ~clk;

   ysyx_220053_mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_memop      (lsu_memop),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_memop      (mem_memop),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   typedef struct {
      bit          own_ifu;
      logic [63:0] addr;
      logic [2:0]  memop;
      logic        wen;
      logic [63:0] wdata;
   } req_t;

   typedef struct {
      bit          own_ifu;
      logic [63:0] data;
      int          due;
   } rsp_t;

   // Memory model configuration (written by the stimulus process)
   int          rdy_pct       = 100;
   int          dly_lo        = 0;
   int          dly_hi        = 0;
   int          hold_cfg      = 0;
   bit          resp_in_issue = 1'b0;
   bit          use_fixed     = 1'b0;
   logic [63:0] fixed_data    = '0;

   // Directed-check controls (written by the stimulus process)
   bit lat_test  = 1'b0;
   bit seq_test  = 1'b0;
   int seq_base  = 0;
   bit final_chk = 1'b0;

   // Monitor / model state (written only by the monitor)
   req_t        req_q[$];
   rsp_t        rsp_q[$];
   bit          glog[$];
   int          n_chk = 0;
   int          n_err = 0;
   bit          busy = 1'b0;
   bit          mem_waiting = 1'b0;
   bit          cur_own = 1'b0;
   int          m_starve = 0;
   int          last_grant_cyc = 0;
   int          resp_cnt = 0;
   int          macc_cnt = 0;
   bit          seq_done = 1'b0;
   bit          final_done = 1'b0;
   logic [31:0] exp_ifu_rdata = '0;
   logic [63:0] exp_lsu_rdata = '0;
   logic        exp_i;
   logic        exp_l;

   int cyc = 0;
   bit rst_seen = 1'b0;

   // Cycle counter and record of whether the last edge applied reset
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory model: random accept delay and response latency, one transaction at a time
   bit pend = 1'b0;
   int pwait = 0;
   int iss_cnt = 0;
   always begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
         pend  = 1'b1;
         pwait = $urandom_range(dly_lo, dly_hi);
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (pend) begin
         if (pwait == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = use_fixed ? fixed_data : {$urandom, $urandom};
            pend           = 1'b0;
         end else begin
            pwait--;
         end
      end
      if (mem_req_valid) begin
         mem_req_ready = (iss_cnt >= hold_cfg) && (int'($urandom_range(0, 99)) < rdy_pct);
         iss_cnt++;
         if (resp_in_issue && mem_req_ready) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 64'hDEAD_BEEF_0BAD_F00D;
         end
      end else begin
         mem_req_ready = 1'b0;
         iss_cnt       = 0;
      end
   end

   // Scoreboard monitor: grants, memory requests, responses, held data
   always @(negedge clk) begin
      req_t r;
      rsp_t s;
      bit   resp_now;
      resp_now = 1'b0;
      if (rst_seen) begin
         chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
         chk("rst_ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
         chk("rst_lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
         chk("rst_mem_addr", mem_addr, 64'd0);
         chk("rst_mem_memop", 64'(mem_memop), 64'd0);
         chk("rst_mem_wen", 64'(mem_wen), 64'd0);
         chk("rst_mem_wdata", mem_wdata, 64'd0);
         chk("rst_ifu_rdata", 64'(ifu_rdata), 64'd0);
         chk("rst_lsu_rdata", lsu_rdata, 64'd0);
         if (rst || !(ifu_req_valid || lsu_req_valid)) begin
            chk("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
            chk("rst_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
         end
         req_q.delete();
         rsp_q.delete();
         busy          = 1'b0;
         mem_waiting   = 1'b0;
         m_starve      = 0;
         exp_ifu_rdata = '0;
         exp_lsu_rdata = '0;
      end else begin
         // responses returned to the requesters
         if (ifu_resp_valid || lsu_resp_valid) begin
            resp_cnt++;
            resp_now = 1'b1;
            chk("resp_both", 64'(ifu_resp_valid & lsu_resp_valid), 64'd0);
            if (rsp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL resp_unexpected: got ifu_resp=%b lsu_resp=%b, required no pulse", ifu_resp_valid, lsu_resp_valid);
            end else begin
               s = rsp_q.pop_front();
               chk("resp_cycle", 64'(cyc), 64'(s.due));
               chk("resp_owner_ifu", 64'(ifu_resp_valid), 64'(s.own_ifu));
               chk("resp_owner_lsu", 64'(lsu_resp_valid), 64'(!s.own_ifu));
               if (s.own_ifu) exp_ifu_rdata = s.data[31:0];
               else           exp_lsu_rdata = s.data;
               if (lat_test) chk("latency", 64'(cyc - last_grant_cyc), 64'd3);
            end
         end else if (rsp_q.size() > 0 && cyc > rsp_q[0].due) begin
            n_chk++;
            n_err++;
            $display("FAIL resp_missing: got no pulse at cycle %0d, required one", rsp_q[0].due);
            void'(rsp_q.pop_front());
            resp_now = 1'b1;
         end
         chk("ifu_rdata", 64'(ifu_rdata), 64'(exp_ifu_rdata));
         chk("lsu_rdata", lsu_rdata, exp_lsu_rdata);

         // memory response for the transaction in flight
         if (mem_waiting && mem_resp_valid) begin
            s.own_ifu = cur_own;
            s.data    = mem_rdata;
            s.due     = cyc + 1;
            rsp_q.push_back(s);
            mem_waiting = 1'b0;
         end

         // memory request fields, every cycle they are presented
         if (mem_req_valid) begin
            if (req_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL mem_req_unexpected: got mem_req_valid=1, required 0");
            end else begin
               chk("mem_addr", mem_addr, req_q[0].addr);
               chk("mem_memop", 64'(mem_memop), 64'(req_q[0].memop));
               chk("mem_wen", 64'(mem_wen), 64'(req_q[0].wen));
               chk("mem_wdata", mem_wdata, req_q[0].wdata);
               if (mem_req_ready) begin
                  cur_own = req_q[0].own_ifu;
                  void'(req_q.pop_front());
                  mem_waiting = 1'b1;
                  macc_cnt++;
               end
            end
         end

         // grant decision
         exp_l = !busy && lsu_req_valid && !(ifu_req_valid && (m_starve == STARVE_MAX));
         exp_i = !busy && ifu_req_valid && !exp_l;
         if (exp_l || exp_i || ifu_req_ready || lsu_req_ready) begin
            chk("grant", 64'({ifu_req_ready, lsu_req_ready}), 64'({exp_i, exp_l}));
         end
         if (ifu_req_ready && ifu_req_valid) begin
            r.own_ifu = 1'b1;
            r.addr    = ifu_addr;
            r.memop   = 3'b100;
            r.wen     = 1'b0;
            r.wdata   = '0;
            req_q.push_back(r);
            m_starve  = 0;
            glog.push_back(1'b1);
            busy = 1'b1;
            last_grant_cyc = cyc;
         end else if (lsu_req_ready && lsu_req_valid) begin
            r.own_ifu = 1'b0;
            r.addr    = lsu_addr;
            r.memop   = lsu_memop;
            r.wen     = lsu_wen;
            r.wdata   = lsu_wdata;
            req_q.push_back(r);
            if (ifu_req_valid && m_starve < STARVE_MAX) m_starve++;
            glog.push_back(1'b0);
            busy = 1'b1;
            last_grant_cyc = cyc;
         end else if (resp_now) begin
            busy = 1'b0;
         end

         // starvation grant order: L L L L I L
         if (seq_test && !seq_done && (glog.size() - seq_base >= 6)) begin
            chk("seq_g0", 64'(glog[seq_base + 0]), 64'd0);
            chk("seq_g1", 64'(glog[seq_base + 1]), 64'd0);
            chk("seq_g2", 64'(glog[seq_base + 2]), 64'd0);
            chk("seq_g3", 64'(glog[seq_base + 3]), 64'd0);
            chk("seq_g4", 64'(glog[seq_base + 4]), 64'd1);
            chk("seq_g5", 64'(glog[seq_base + 5]), 64'd0);
            seq_done = 1'b1;
         end

         if (final_chk && !final_done) begin
            chk("req_q_empty", 64'(req_q.size()), 64'd0);
            chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
            chk("idle_at_end", 64'(busy), 64'd0);
            final_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit ifu_acc = 1'b0;
   bit lsu_acc = 1'b0;

   task automatic step();
      @(negedge clk);
      ifu_acc = ifu_req_valid && ifu_req_ready;
      lsu_acc = lsu_req_valid && lsu_req_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic give_up(input string what);
      $display("FAIL timeout_%s: got no progress within bound, required progress", what);
      $fatal(1, "bench stopped");
   endtask

   task automatic wait_resp_to(input int target);
      int n;
      n = 0;
      while (resp_cnt < target) begin
         if (n == 300) give_up("resp");
         step();
         n++;
      end
   endtask

   task automatic issue_ifu(input logic [63:0] a);
      int n;
      ifu_req_valid = 1'b1;
      ifu_addr      = a;
      n = 0;
      do begin
         if (n == 300) give_up("ifu_grant");
         step();
         n++;
      end while (!ifu_acc);
      ifu_req_valid = 1'b0;
      ifu_addr      = {$urandom, $urandom};
   endtask

   task automatic issue_lsu(input logic [63:0] a, input logic [2:0] op, input logic w, input logic [63:0] d);
      int n;
      lsu_req_valid = 1'b1;
      lsu_addr      = a;
      lsu_memop     = op;
      lsu_wen       = w;
      lsu_wdata     = d;
      n = 0;
      do begin
         if (n == 300) give_up("lsu_grant");
         step();
         n++;
      end while (!lsu_acc);
      lsu_req_valid = 1'b0;
      lsu_wdata     = {$urandom, $urandom};
   endtask

   task automatic new_lsu_fields();
      lsu_addr  = {32'h0, $urandom};
      lsu_memop = 3'($urandom_range(0, 6));
      lsu_wen   = 1'($urandom_range(0, 1));
      lsu_wdata = {$urandom, $urandom};
   endtask

   initial begin
      int base;
      int n;
      rst           = 1'b1;
      ifu_req_valid = 1'b0;
      ifu_addr      = '0;
      lsu_req_valid = 1'b0;
      lsu_addr      = '0;
      lsu_memop     = '0;
      lsu_wen       = 1'b0;
      lsu_wdata     = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // IFU fetch, zero-wait memory, minimum latency
      base       = resp_cnt;
      use_fixed  = 1'b1;
      fixed_data = 64'hFFFF_FFFF_0000_0013;
      lat_test   = 1'b1;
      issue_ifu(64'h8000_0000);
      wait_resp_to(base + 1);
      lat_test   = 1'b0;
      use_fixed  = 1'b0;
      step();

      // both valid: LSU first, IFU after
      base = resp_cnt;
      new_lsu_fields();
      lsu_req_valid = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0004;
      n = 0;
      while (ifu_req_valid || lsu_req_valid) begin
         if (n == 300) give_up("both");
         step();
         n++;
         if (lsu_acc) lsu_req_valid = 1'b0;
         if (ifu_acc) ifu_req_valid = 1'b0;
      end
      wait_resp_to(base + 2);
      step();

      // starvation bound with continuous requests
      base     = resp_cnt;
      seq_base = glog.size();
      seq_test = 1'b1;
      new_lsu_fields();
      lsu_req_valid = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_addr      = 64'h8000_0008;
      n = 0;
      while (!seq_done) begin
         if (n == 500) give_up("starve_seq");
         step();
         n++;
         if (!seq_done) begin
            if (lsu_acc) new_lsu_fields();
            if (ifu_acc) ifu_req_valid = 1'b0;
         end
      end
      lsu_req_valid = 1'b0;
      ifu_req_valid = 1'b0;
      seq_test      = 1'b0;
      wait_resp_to(base + 6);
      step();

      // byte store with memory back-pressure
      base     = resp_cnt;
      hold_cfg = 3;
      issue_lsu(64'h8000_20d1, 3'b001, 1'b1, 64'hAB);
      wait_resp_to(base + 1);
      hold_cfg = 0;
      step();

      // reset in WAIT, late memory response, then a normal fetch
      dly_lo = 3;
      dly_hi = 3;
      base   = macc_cnt;
      issue_ifu(64'h8000_0010);
      n = 0;
      while (macc_cnt == base) begin
         if (n == 300) give_up("mem_accept");
         step();
         n++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (6) step();
      dly_lo = 0;
      dly_hi = 0;
      base   = resp_cnt;
      issue_ifu(64'h8000_0014);
      wait_resp_to(base + 1);
      step();

      // stray response in ISSUE must be ignored
      base          = resp_cnt;
      resp_in_issue = 1'b1;
      dly_lo        = 1;
      dly_hi        = 1;
      new_lsu_fields();
      issue_lsu(lsu_addr, 3'b011, 1'b0, '0);
      wait_resp_to(base + 1);
      resp_in_issue = 1'b0;
      step();

      // random traffic
      rdy_pct = 70;
      dly_lo  = 0;
      dly_hi  = 3;
      for (int i = 0; i < 600; i++) begin
         step();
         if (ifu_acc) ifu_req_valid = 1'b0;
         if (lsu_acc) lsu_req_valid = 1'b0;
         if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
            ifu_req_valid = 1'b1;
            ifu_addr      = {32'h0, $urandom};
         end
         if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
            lsu_req_valid = 1'b1;
            new_lsu_fields();
         end
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      repeat (30) step();
      final_chk = 1'b1;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
